// File: rtl/regs_mp_pkg.sv
// regs_mp_pkg: shared definitions for the multi-read-port register file.
//   - default parameter values
//   - clear/run FSM state encoding
//   - per-port read-source select encoding
//   - storage style switch for the banks
package regs_mp_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_N_RD     = 2;
  localparam bit DEF_ZERO_REG = 1'b1;
  localparam bit DEF_BYPASS   = 1'b1;

  // 1 = banks request distributed (LUT) RAM, 0 = block RAM.
  localparam bit REGS_DISTRIBUTED = 1'b1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Source of a read port's output value, captured at the read edge.
  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_BANK = 2'd1,
    SEL_BYP  = 2'd2
  } rd_sel_e;

endpackage

// File: rtl/regs_mp_if.sv
// regs_mp_if: decode/writeback side bus of the register file.
//   i_ce       clock enable for writes and read-output updates
//   i_rd_en    per-port read enable
//   i_addr_rd  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   i_we       write enable
//   i_addr_wr  write address
//   i_dat_wr   write data
//   o_dat_rd   packed read data, port k at [k*DATA_W +: DATA_W]
//   o_busy     high while the post-reset clear runs
// master = pipeline side, slave = register file.
interface regs_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_RD   = 2
);

  logic                     i_ce;
  logic [N_RD-1:0]          i_rd_en;
  logic [N_RD*ADDR_W-1:0]   i_addr_rd;
  logic                     i_we;
  logic [ADDR_W-1:0]        i_addr_wr;
  logic [DATA_W-1:0]        i_dat_wr;
  logic [N_RD*DATA_W-1:0]   o_dat_rd;
  logic                     o_busy;

  modport master (
    output i_ce, i_rd_en, i_addr_rd, i_we, i_addr_wr, i_dat_wr,
    input  o_dat_rd, o_busy
  );

  modport slave (
    input  i_ce, i_rd_en, i_addr_rd, i_we, i_addr_wr, i_dat_wr,
    output o_dat_rd, o_busy
  );

endinterface

// File: rtl/regs_mp_bank.sv
// regs_bank: one DEPTH x DATA_W storage array, one write port and one
// synchronous read port (read-before-write on an address collision).
//   i_clk    clock
//   i_we     write strobe
//   i_waddr  write address
//   i_wdata  write data
//   i_re     read strobe; o_rdata holds when low
//   i_raddr  read address
//   o_rdata  registered read data
module regs_bank
  import regs_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_rdata;

  // The array carries the storage style attribute, so each style gets
  // its own declaration; only one branch is elaborated.
  if (REGS_DISTRIBUTED) begin : g_dist
    (* ram_style = "distributed" *) logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
    end
  end else begin : g_block
    (* ram_style = "block" *) logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/regs_mp.sv
// regs_mp: integer register file with N_RD synchronous read ports, one
// write port, optional same-cycle write-to-read bypass, optional
// hardwired-zero entry 0, and a hardware clear of every entry after reset.
//   i_clk  clock, rising edge
//   i_rst  synchronous active-high reset
//   bus    regs_mp_if slave (read/write ports, o_dat_rd, o_busy)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | writing 0 to entry[r_clr_cnt] each cycle, o_busy high,
//          | user reads/writes dropped, read outputs forced to 0
// ST_RUN   | normal register file operation
module regs_mp
  import regs_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_RD     = DEF_N_RD,
  parameter bit ZERO_REG = DEF_ZERO_REG,
  parameter bit BYPASS   = DEF_BYPASS
) (
  input  logic       i_clk,
  input  logic       i_rst,
  regs_mp_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [ADDR_W-1:0]  r_clr_cnt;
  logic [ADDR_W-1:0]  w_clr_cnt_nxt;

  logic               w_run;
  logic               w_clearing;
  logic               w_user_we;
  logic               w_bank_we;
  logic [ADDR_W-1:0]  w_bank_waddr;
  logic [DATA_W-1:0]  w_bank_wdata;

  logic [DATA_W-1:0]  w_port_dat [N_RD];
  logic [N_RD*DATA_W-1:0] w_dat_rd;

  // Clear FSM
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    if (r_state == ST_CLEAR) begin
      w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
      if (r_clr_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = ST_RUN;
    end
  end

  // Nothing reaches the banks on a reset cycle; the clear restarts at 0.
  assign w_run      = (r_state == ST_RUN) && !i_rst;
  assign w_clearing = (r_state == ST_CLEAR) && !i_rst;

  assign w_user_we  = w_run && bus.i_ce && bus.i_we &&
                      !(ZERO_REG && (bus.i_addr_wr == '0));

  assign w_bank_we    = w_clearing || w_user_we;
  assign w_bank_waddr = w_clearing ? r_clr_cnt : bus.i_addr_wr;
  assign w_bank_wdata = w_clearing ? '0 : bus.i_dat_wr;

  // One bank per read port, all written identically. The bank keeps its
  // own read register; the port register below only records where the
  // captured value comes from (bank, bypassed write data, or zero).
  for (genvar k = 0; k < N_RD; k++) begin : g_port
    logic [ADDR_W-1:0] w_raddr;
    logic              w_re;
    logic [DATA_W-1:0] w_bank_rdata;
    rd_sel_e           r_sel;
    logic [DATA_W-1:0] r_byp;

    assign w_raddr = bus.i_addr_rd[k*ADDR_W +: ADDR_W];
    assign w_re    = w_run && bus.i_ce && bus.i_rd_en[k];

    regs_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .i_clk   (i_clk),
      .i_we    (w_bank_we),
      .i_waddr (w_bank_waddr),
      .i_wdata (w_bank_wdata),
      .i_re    (w_re),
      .i_raddr (w_raddr),
      .o_rdata (w_bank_rdata)
    );

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_sel <= SEL_ZERO;
        r_byp <= '0;
      end else if (r_state == ST_CLEAR) begin
        r_sel <= SEL_ZERO;
      end else if (w_re) begin
        if (ZERO_REG && (w_raddr == '0)) begin
          r_sel <= SEL_ZERO;
        end else if (BYPASS && w_user_we && (w_raddr == bus.i_addr_wr)) begin
          r_sel <= SEL_BYP;
          r_byp <= bus.i_dat_wr;
        end else begin
          r_sel <= SEL_BANK;
        end
      end
    end

    always_comb begin
      w_port_dat[k] = '0;
      case (r_sel)
        SEL_BANK: w_port_dat[k] = w_bank_rdata;
        SEL_BYP:  w_port_dat[k] = r_byp;
        default:  w_port_dat[k] = '0;
      endcase
    end
  end

  always_comb begin
    w_dat_rd = '0;
    for (int k = 0; k < N_RD; k++) begin
      w_dat_rd[k*DATA_W +: DATA_W] = w_port_dat[k];
    end
  end

  assign bus.o_dat_rd = w_dat_rd;
  assign bus.o_busy   = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_regs_mp.sv
module tb_regs_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [1:0]  rd_en;
  logic [9:0]  addr_rd;
  logic        we;
  logic [4:0]  addr_wr;
  logic [31:0] dat_wr;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: register contents plus the value each port should show,
  // for the bypassing (exp1) and read-before-write (exp0) instances.
  logic [31:0] m_mem  [32];
  logic [31:0] m_exp1 [2];
  logic [31:0] m_exp0 [2];
  int          m_clr_left;
  bit          m_busy;

  always #5 clk = ~clk;

  regs_mp_if #(.DATA_W(32), .ADDR_W(5), .N_RD(2)) bus1 ();
  regs_mp_if #(.DATA_W(32), .ADDR_W(5), .N_RD(2)) bus0 ();

  assign bus1.i_ce = ce;      assign bus0.i_ce = ce;
  assign bus1.i_rd_en = rd_en;    assign bus0.i_rd_en = rd_en;
  assign bus1.i_addr_rd = addr_rd;  assign bus0.i_addr_rd = addr_rd;
  assign bus1.i_we = we;      assign bus0.i_we = we;
  assign bus1.i_addr_wr = addr_wr;  assign bus0.i_addr_wr = addr_wr;
  assign bus1.i_dat_wr = dat_wr;    assign bus0.i_dat_wr = dat_wr;

  regs_mp #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1))
    u_dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
  regs_mp #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b0))
    u_dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));

  function automatic logic [31:0] p1(int k);
    return bus1.o_dat_rd[k*32 +: 32];
  endfunction

  function automatic logic [31:0] p0(int k);
    return bus0.o_dat_rd[k*32 +: 32];
  endfunction

  // Advance one clock; inputs stay stable until after the model update.
  task automatic tick();
    logic [4:0] a;
    bit         wr;
    @(posedge clk);
    #1;
    if (rst) begin
      m_clr_left = 32;
      m_busy     = 1'b1;
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      for (int k = 0; k < 2; k++) begin m_exp1[k] = '0; m_exp0[k] = '0; end
    end else if (m_clr_left > 0) begin
      m_clr_left--;
      m_busy = (m_clr_left > 0);
    end else begin
      wr = ce && we && (addr_wr != 5'd0);
      for (int k = 0; k < 2; k++) begin
        if (ce && rd_en[k]) begin
          a = addr_rd[k*5 +: 5];
          if (a == 5'd0) begin
            m_exp1[k] = '0;
            m_exp0[k] = '0;
          end else begin
            m_exp0[k] = m_mem[a];
            m_exp1[k] = (wr && a == addr_wr) ? dat_wr : m_mem[a];
          end
        end
      end
      if (wr) m_mem[addr_wr] = dat_wr;
    end
  endtask

  task automatic idle();
    ce = 1'b1; rd_en = 2'b00; we = 1'b0;
  endtask

  task automatic test_reset();
    int busy_high;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (bus1.o_busy !== 1'b1 || bus0.o_busy !== 1'b1 || bus1.o_dat_rd !== '0) begin
      $display("FAIL reset_state busy=%b/%b dat=%h required busy=1 dat=0",
               bus1.o_busy, bus0.o_busy, bus1.o_dat_rd);
      n_fail++;
    end
    // Reads and writes issued during the clear must be dropped.
    we = 1'b1; addr_wr = 5'd9; dat_wr = 32'h5555_AAAA; rd_en = 2'b11;
    addr_rd = {5'd9, 5'd9};
    busy_high = 0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (bus1.o_busy === 1'b1) busy_high++;
      n_tests++;
      if (bus1.o_busy !== (i < 32) || bus0.o_busy !== (i < 32) ||
          bus1.o_dat_rd !== '0 || bus0.o_dat_rd !== '0) begin
        $display("FAIL clear_cycle%0d busy=%b dat=%h required busy=%b dat=0",
                 i, bus1.o_busy, bus1.o_dat_rd, (i < 32));
        n_fail++;
      end
    end
    n_tests++;
    if (busy_high != 31) begin
      $display("FAIL clear_length busy_edges=%0d required 31", busy_high);
      n_fail++;
    end
    idle();
    rd_en = 2'b11;
    for (int a = 0; a < 32; a++) begin
      addr_rd = {5'(a), 5'(a)};
      tick();
      n_tests++;
      if (bus1.o_dat_rd !== '0 || bus0.o_dat_rd !== '0) begin
        $display("FAIL cleared_x%0d got %h/%h required 0", a, bus1.o_dat_rd, bus0.o_dat_rd);
        n_fail++;
      end
    end
  endtask

  task automatic test_write_read();
    idle();
    we = 1'b1; addr_wr = 5'd5; dat_wr = 32'hDEAD_BEEF;
    tick();
    idle();
    rd_en = 2'b11; addr_rd = {5'd0, 5'd5};
    tick();
    n_tests++;
    if (p1(0) !== 32'hDEAD_BEEF || p1(1) !== 32'h0 ||
        p0(0) !== 32'hDEAD_BEEF || p0(1) !== 32'h0) begin
      $display("FAIL write_read got %h,%h / %h,%h required deadbeef,0",
               p1(0), p1(1), p0(0), p0(1));
      n_fail++;
    end
  endtask

  task automatic test_bypass();
    idle();
    we = 1'b1; addr_wr = 5'd7; dat_wr = 32'h1234_5678;
    rd_en = 2'b11; addr_rd = {5'd7, 5'd7};
    tick();
    n_tests++;
    if (p1(0) !== 32'h1234_5678 || p1(1) !== 32'h1234_5678) begin
      $display("FAIL bypass_on got %h,%h required 12345678", p1(0), p1(1));
      n_fail++;
    end
    n_tests++;
    if (p0(0) !== 32'h0 || p0(1) !== 32'h0) begin
      $display("FAIL bypass_off got %h,%h required 0 (old value)", p0(0), p0(1));
      n_fail++;
    end
    we = 1'b0;
    tick();
    n_tests++;
    if (p0(0) !== 32'h1234_5678 || p0(1) !== 32'h1234_5678) begin
      $display("FAIL after_write got %h,%h required 12345678", p0(0), p0(1));
      n_fail++;
    end
  endtask

  task automatic test_hold_ce();
    idle();
    rd_en = 2'b01; addr_rd = {5'd7, 5'd5};
    tick();
    rd_en = 2'b00; addr_rd = {5'd6, 5'd6};
    tick();
    n_tests++;
    if (p1(0) !== 32'hDEAD_BEEF || p0(0) !== 32'hDEAD_BEEF) begin
      $display("FAIL rd_en_hold got %h/%h required deadbeef", p1(0), p0(0));
      n_fail++;
    end
    ce = 1'b0; we = 1'b1; addr_wr = 5'd6; dat_wr = 32'hCAFE_F00D; rd_en = 2'b11;
    tick();
    n_tests++;
    if (p1(0) !== 32'hDEAD_BEEF || p1(1) !== 32'h1234_5678 ||
        p0(0) !== 32'hDEAD_BEEF || p0(1) !== 32'h1234_5678) begin
      $display("FAIL ce_hold got %h,%h / %h,%h required deadbeef,12345678",
               p1(0), p1(1), p0(0), p0(1));
      n_fail++;
    end
    idle();
    rd_en = 2'b11; addr_rd = {5'd6, 5'd6};
    tick();
    n_tests++;
    if (p1(0) !== 32'h0 || p1(1) !== 32'h0 || p0(0) !== 32'h0) begin
      $display("FAIL ce_write_dropped x6 got %h,%h required 0", p1(0), p1(1));
      n_fail++;
    end
  endtask

  task automatic test_zero_reg();
    idle();
    rd_en = 2'b11; addr_rd = {5'd5, 5'd5};
    tick();
    we = 1'b1; addr_wr = 5'd0; dat_wr = 32'hFFFF_FFFF; addr_rd = {5'd0, 5'd0};
    tick();
    n_tests++;
    if (p1(0) !== 32'h0 || p1(1) !== 32'h0 || p0(0) !== 32'h0) begin
      $display("FAIL zero_same_cycle got %h,%h required 0", p1(0), p1(1));
      n_fail++;
    end
    we = 1'b0;
    tick();
    n_tests++;
    if (p1(0) !== 32'h0 || p1(1) !== 32'h0 || p0(1) !== 32'h0) begin
      $display("FAIL zero_later got %h,%h required 0", p1(0), p1(1));
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    idle();
    we = 1'b1; addr_wr = 5'd3; dat_wr = 32'h0000_00AA;
    tick();
    idle();
    rd_en = 2'b01; addr_rd = {5'd0, 5'd3};
    tick();
    n_tests++;
    if (p1(0) !== 32'hAA) begin
      $display("FAIL x3_written got %h required aa", p1(0));
      n_fail++;
    end
    idle();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n = 0;
    while (bus1.o_busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    n_tests++;
    if (n != 32) begin
      $display("FAIL mid_clear_restart busy_cycles=%0d required 32", n);
      n_fail++;
    end
    rd_en = 2'b11; addr_rd = {5'd3, 5'd3};
    tick();
    n_tests++;
    if (p1(0) !== 32'h0 || p0(1) !== 32'h0) begin
      $display("FAIL x3_after_clear got %h/%h required 0", p1(0), p0(1));
      n_fail++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      ce      = ($urandom_range(0, 9) != 0);
      we      = $urandom_range(0, 1);
      addr_wr = 5'($urandom_range(0, 7));
      dat_wr  = $urandom;
      rd_en   = 2'($urandom_range(0, 3));
      addr_rd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      tick();
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (p1(k) !== m_exp1[k] || p0(k) !== m_exp0[k]) begin
          $display("FAIL random_c%0d_p%0d got %h/%h required %h/%h",
                   c, k, p1(k), p0(k), m_exp1[k], m_exp0[k]);
          n_fail++;
        end
      end
      n_tests++;
      if (bus1.o_busy !== m_busy) begin
        $display("FAIL random_busy_c%0d got %b required %b", c, bus1.o_busy, m_busy);
        n_fail++;
      end
    end
  endtask

  task automatic test_back_to_back();
    // Write then immediately read the same register on consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      idle();
      we = 1'b1; addr_wr = 5'(8 + i); dat_wr = $urandom;
      rd_en = 2'b10; addr_rd = {5'(7 + i), 5'd0};
      tick();
      n_tests++;
      if (p1(1) !== m_exp1[1] || p0(1) !== m_exp0[1]) begin
        $display("FAIL b2b_%0d got %h/%h required %h/%h",
                 i, p1(1), p0(1), m_exp1[1], m_exp0[1]);
        n_fail++;
      end
    end
  endtask

  initial begin
    rst = 1'b0; ce = 1'b1; rd_en = '0; addr_rd = '0; we = 1'b0;
    addr_wr = '0; dat_wr = '0; m_clr_left = 0; m_busy = 1'b1;
    for (int k = 0; k < 2; k++) begin m_exp1[k] = '0; m_exp0[k] = '0; end
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_bypass();
    test_hold_ce();
    test_zero_reg();
    test_back_to_back();
    test_reset_mid_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
